// File: rtl/screen_receiver.sv
// Display-side receiver for the SSD1306-style 4-wire serial bus.
// Deserialises bytes, decodes commands into config registers, writes data to a framebuffer port.
//
// Ports:
//   clk, rst_btn (sync, active-low)
//   ioSclk, ioSdin, ioCs (active-low), ioDc, ioReset (active-low) : bus lines
//   fbWe, fbAddr {page,col}, fbData              : framebuffer write port
//   byteValid, byteData, byteIsData              : per-byte monitor pulse
//   displayOn, contrast, inverted, entireOn, chargePump, startLine,
//   segRemap, comScanDec, muxRatio, displayOffset, addrMode : config
module screen_receiver (
    input  logic       clk,
    input  logic       rst_btn,
    input  logic       ioSclk,
    input  logic       ioSdin,
    input  logic       ioCs,
    input  logic       ioDc,
    input  logic       ioReset,
    output logic       fbWe,
    output logic [9:0] fbAddr,
    output logic [7:0] fbData,
    output logic       byteValid,
    output logic [7:0] byteData,
    output logic       byteIsData,
    output logic       displayOn,
    output logic [7:0] contrast,
    output logic       inverted,
    output logic       entireOn,
    output logic       chargePump,
    output logic [5:0] startLine,
    output logic       segRemap,
    output logic       comScanDec,
    output logic [5:0] muxRatio,
    output logic [5:0] displayOffset,
    output logic [1:0] addrMode
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG1 = 2'd1,
        ARG2 = 2'd2
    } dec_state_t;

    // Bus idle pattern: {sclk, sdin, cs, dc, reset}
    localparam logic [4:0] BUS_IDLE = 5'b00101;

    logic [4:0] sync1;
    logic [4:0] sync2;
    logic       sclk_q;
    logic       cs_q;

    logic       sclk_s;
    logic       sdin_s;
    logic       cs_s;
    logic       dc_s;
    logic       nrst_s;
    logic       rst_int;

    logic       sclk_rise;
    logic       bit_take;
    logic       byte_done;
    logic [7:0] rx_byte;

    logic [6:0] shreg;
    logic [2:0] bit_cnt;

    dec_state_t state;
    logic [7:0] op;
    logic [6:0] arg1;
    logic       is_arg1;
    logic       is_arg2;

    logic [6:0] col;
    logic [2:0] page;
    logic [6:0] col_start;
    logic [6:0] col_end;
    logic [2:0] page_start;
    logic [2:0] page_end;
    logic       adv_pend;

    // Synchronisers are only cleared by rst_btn so that a low ioReset
    // keeps propagating and its release is seen.
    always_ff @(posedge clk) begin
        if (!rst_btn) begin
            sync1  <= BUS_IDLE;
            sync2  <= BUS_IDLE;
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
        end else begin
            sync1  <= {ioSclk, ioSdin, ioCs, ioDc, ioReset};
            sync2  <= sync1;
            sclk_q <= sync2[4];
            cs_q   <= sync2[2];
        end
    end

    assign sclk_s  = sync2[4];
    assign sdin_s  = sync2[3];
    assign cs_s    = sync2[2];
    assign dc_s    = sync2[1];
    assign nrst_s  = sync2[0];
    assign rst_int = !rst_btn || !nrst_s;

    assign sclk_rise = sclk_s & ~sclk_q;
    // cs_q lets a CS rise coincident with the last SCLK rise still finish the byte.
    assign bit_take  = sclk_rise & (~cs_s | ~cs_q);
    assign byte_done = bit_take & (bit_cnt == 3'd7);
    assign rx_byte   = {shreg, sdin_s};

    assign is_arg1 = (rx_byte == 8'h81) || (rx_byte == 8'h20) ||
                     (rx_byte == 8'hA8) || (rx_byte == 8'hD3) ||
                     (rx_byte == 8'h8D) || (rx_byte == 8'hD5) ||
                     (rx_byte == 8'hD9) || (rx_byte == 8'hDB);
    assign is_arg2 = (rx_byte == 8'h21) || (rx_byte == 8'h22);

    always_ff @(posedge clk) begin
        if (rst_int) begin
            shreg   <= 7'd0;
            bit_cnt <= 3'd0;
        end else if (cs_s) begin
            shreg   <= 7'd0;
            bit_cnt <= 3'd0;
        end else if (bit_take) begin
            shreg   <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_int) begin
            fbWe          <= 1'b0;
            fbAddr        <= 10'd0;
            fbData        <= 8'd0;
            byteValid     <= 1'b0;
            byteData      <= 8'd0;
            byteIsData    <= 1'b0;
            displayOn     <= 1'b0;
            contrast      <= 8'h7F;
            inverted      <= 1'b0;
            entireOn      <= 1'b0;
            chargePump    <= 1'b0;
            startLine     <= 6'd0;
            segRemap      <= 1'b0;
            comScanDec    <= 1'b0;
            muxRatio      <= 6'd63;
            displayOffset <= 6'd0;
            addrMode      <= 2'b10;
            col           <= 7'd0;
            page          <= 3'd0;
            col_start     <= 7'd0;
            col_end       <= 7'd127;
            page_start    <= 3'd0;
            page_end      <= 3'd7;
            state         <= IDLE;
            op            <= 8'd0;
            arg1          <= 7'd0;
            adv_pend      <= 1'b0;
        end else begin
            fbWe      <= 1'b0;
            byteValid <= 1'b0;
            adv_pend  <= 1'b0;

            // Pointer moves the cycle after the write strobe.
            if (adv_pend) begin
                unique case (addrMode)
                    2'b00: begin
                        if (col == col_end) begin
                            col  <= col_start;
                            page <= (page == page_end) ? page_start
                                                       : page + 3'd1;
                        end else begin
                            col <= col + 7'd1;
                        end
                    end
                    2'b01: begin
                        if (page == page_end) begin
                            page <= page_start;
                            col  <= (col == col_end) ? col_start
                                                     : col + 7'd1;
                        end else begin
                            page <= page + 3'd1;
                        end
                    end
                    default: col <= col + 7'd1;
                endcase
            end

            if (byte_done) begin
                byteValid  <= 1'b1;
                byteData   <= rx_byte;
                byteIsData <= dc_s;
                if (dc_s) begin
                    // Data aborts any pending command.
                    state    <= IDLE;
                    fbWe     <= 1'b1;
                    fbAddr   <= {page, col};
                    fbData   <= rx_byte;
                    adv_pend <= 1'b1;
                end else begin
                    unique case (state)
                        IDLE: begin
                            unique case (1'b1)
                                (rx_byte[7:1] == 7'b1010111):
                                    displayOn <= rx_byte[0];
                                (rx_byte[7:1] == 7'b1010011):
                                    inverted <= rx_byte[0];
                                (rx_byte[7:1] == 7'b1010010):
                                    entireOn <= rx_byte[0];
                                (rx_byte[7:1] == 7'b1010000):
                                    segRemap <= rx_byte[0];
                                (rx_byte[7:6] == 2'b01):
                                    startLine <= rx_byte[5:0];
                                (rx_byte == 8'hC0):
                                    comScanDec <= 1'b0;
                                (rx_byte == 8'hC8):
                                    comScanDec <= 1'b1;
                                (rx_byte[7:3] == 5'b10110):
                                    page <= rx_byte[2:0];
                                (rx_byte[7:4] == 4'h0):
                                    col[3:0] <= rx_byte[3:0];
                                (rx_byte[7:4] == 4'h1):
                                    col[6:4] <= rx_byte[2:0];
                                (is_arg1 || is_arg2): begin
                                    op    <= rx_byte;
                                    state <= ARG1;
                                end
                                default: ;
                            endcase
                        end
                        ARG1: begin
                            if (op == 8'h21 || op == 8'h22) begin
                                arg1  <= rx_byte[6:0];
                                state <= ARG2;
                            end else begin
                                unique case (op)
                                    8'h81: contrast      <= rx_byte;
                                    8'h20: addrMode      <= rx_byte[1:0];
                                    8'hA8: muxRatio      <= rx_byte[5:0];
                                    8'hD3: displayOffset <= rx_byte[5:0];
                                    8'h8D: chargePump    <= rx_byte[2];
                                    default: ;
                                endcase
                                state <= IDLE;
                            end
                        end
                        ARG2: begin
                            if (op == 8'h21) begin
                                col_start <= arg1;
                                col_end   <= rx_byte[6:0];
                                col       <= arg1;
                            end else begin
                                page_start <= arg1[2:0];
                                page_end   <= rx_byte[2:0];
                                page       <= arg1[2:0];
                            end
                            state <= IDLE;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_screen_receiver.sv
// Scoreboard bench for screen_receiver with a byte-level reference model.
// Stimulus drives the bus on negedges; a monitor checks pulses on negedges.
module tb_screen_receiver;

    logic       clk = 1'b0;
    logic       rst_btn;
    logic       ioSclk, ioSdin, ioCs, ioDc, ioReset;
    logic       fbWe;
    logic [9:0] fbAddr;
    logic [7:0] fbData;
    logic       byteValid;
    logic [7:0] byteData;
    logic       byteIsData;
    logic       displayOn;
    logic [7:0] contrast;
    logic       inverted, entireOn, chargePump;
    logic [5:0] startLine;
    logic       segRemap, comScanDec;
    logic [5:0] muxRatio, displayOffset;
    logic [1:0] addrMode;

    always #5 clk = ~clk;

    screen_receiver dut (
        .clk(clk), .rst_btn(rst_btn),
        .ioSclk(ioSclk), .ioSdin(ioSdin), .ioCs(ioCs),
        .ioDc(ioDc), .ioReset(ioReset),
        .fbWe(fbWe), .fbAddr(fbAddr), .fbData(fbData),
        .byteValid(byteValid), .byteData(byteData),
        .byteIsData(byteIsData),
        .displayOn(displayOn), .contrast(contrast),
        .inverted(inverted), .entireOn(entireOn),
        .chargePump(chargePump), .startLine(startLine),
        .segRemap(segRemap), .comScanDec(comScanDec),
        .muxRatio(muxRatio), .displayOffset(displayOffset),
        .addrMode(addrMode)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int b;
        int d;
        int t;
    } bexp_t;
    typedef struct {
        int a;
        int d;
    } wexp_t;

    bexp_t bq[$];
    wexp_t wq[$];
    int    wlog[$];
    int    bcount = 0;
    bexp_t mb;
    wexp_t mw;

    task automatic chk(string n, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_on, m_contrast, m_inv, m_ent, m_cp, m_start, m_seg, m_com;
    int m_mux, m_off, m_mode;
    int m_col, m_page, m_cs, m_ce, m_ps, m_pe;
    int pend[$];

    task automatic model_reset();
        m_on = 0; m_contrast = 'h7F; m_inv = 0; m_ent = 0; m_cp = 0;
        m_start = 0; m_seg = 0; m_com = 0; m_mux = 63; m_off = 0;
        m_mode = 2; m_col = 0; m_page = 0; m_cs = 0; m_ce = 127;
        m_ps = 0; m_pe = 7;
        pend.delete();
    endtask

    function automatic int nargs(int b);
        case (b)
            'h81, 'h20, 'hA8, 'hD3, 'h8D, 'hD5, 'hD9, 'hDB: return 1;
            'h21, 'h22: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic apply_single(int b);
        if (b == 'hAE || b == 'hAF) m_on = b & 1;
        else if (b == 'hA6 || b == 'hA7) m_inv = b & 1;
        else if (b == 'hA4 || b == 'hA5) m_ent = b & 1;
        else if (b == 'hA0 || b == 'hA1) m_seg = b & 1;
        else if (b inside {['h40:'h7F]}) m_start = b & 63;
        else if (b == 'hC0) m_com = 0;
        else if (b == 'hC8) m_com = 1;
        else if (b inside {['hB0:'hB7]}) m_page = b & 7;
        else if (b inside {['h00:'h0F]}) m_col = (m_col & 'h70) | (b & 15);
        else if (b inside {['h10:'h1F]}) m_col = (m_col & 15) | ((b & 7) << 4);
    endtask

    task automatic apply_multi();
        case (pend[0])
            'h81: m_contrast = pend[1];
            'h20: m_mode = pend[1] & 3;
            'hA8: m_mux = pend[1] & 63;
            'hD3: m_off = pend[1] & 63;
            'h8D: m_cp = (pend[1] >> 2) & 1;
            'h21: begin
                m_cs = pend[1] & 127; m_ce = pend[2] & 127; m_col = m_cs;
            end
            'h22: begin
                m_ps = pend[1] & 7; m_pe = pend[2] & 7; m_page = m_ps;
            end
            default: ;
        endcase
    endtask

    task automatic advance();
        if (m_mode == 0) begin
            if (m_col == m_ce) begin
                m_col = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
            end else m_col = (m_col + 1) % 128;
        end else if (m_mode == 1) begin
            if (m_page == m_pe) begin
                m_page = m_ps;
                m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
            end else m_page = (m_page + 1) % 8;
        end else m_col = (m_col + 1) % 128;
    endtask

    task automatic model_byte(int b, int dc);
        if (dc != 0) begin
            pend.delete();
            wq.push_back('{m_page * 128 + m_col, b});
            advance();
        end else if (pend.size() == 0) begin
            if (nargs(b) == 0) apply_single(b);
            else pend.push_back(b);
        end else begin
            pend.push_back(b);
            if (pend.size() == 1 + nargs(pend[0])) begin
                apply_multi();
                pend.delete();
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (byteValid === 1'b1) begin
            bcount++;
            chk("byte_expected", int'(bq.size() > 0), 1);
            if (bq.size() > 0) begin
                mb = bq.pop_front();
                chk("byte_data", int'(byteData), mb.b);
                chk("byte_is_data", int'(byteIsData), mb.d);
                chk("byte_latency", cyc, mb.t);
            end
        end
        if (fbWe === 1'b1) begin
            wlog.push_back(int'(fbAddr));
            chk("write_expected", int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                mw = wq.pop_front();
                chk("fb_addr", int'(fbAddr), mw.a);
                chk("fb_data", int'(fbData), mw.d);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_neg(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(logic [7:0] b, logic dc, int hp, bit end_cs = 0);
        ioCs = 1'b0;
        ioDc = dc;
        for (int i = 7; i >= 0; i--) begin
            ioSclk = 1'b0;
            ioSdin = b[i];
            wait_neg(hp);
            ioSclk = 1'b1;
            if (i == 0) begin
                if (end_cs) ioCs = 1'b1;
                bq.push_back('{int'(b), int'(dc), cyc + 3});
                model_byte(int'(b), int'(dc));
            end
            wait_neg(hp);
        end
        ioSclk = 1'b0;
    endtask

    task automatic send_bits(logic [7:0] b, int n, int hp);
        ioCs = 1'b0;
        for (int i = 0; i < n; i++) begin
            ioSclk = 1'b0;
            ioSdin = b[7 - i];
            wait_neg(hp);
            ioSclk = 1'b1;
            wait_neg(hp);
        end
        ioSclk = 1'b0;
    endtask

    task automatic cs_high();
        ioCs = 1'b1;
        ioSclk = 1'b0;
        wait_neg(3);
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && (bq.size() > 0 || wq.size() > 0); k++)
            wait_neg(1);
        chk("drain_bytes", bq.size(), 0);
        chk("drain_writes", wq.size(), 0);
        bq.delete();
        wq.delete();
        wait_neg(2);
    endtask

    task automatic do_reset();
        ioCs = 1'b1; ioSclk = 1'b0; ioSdin = 1'b0; ioDc = 1'b0;
        ioReset = 1'b1;
        rst_btn = 1'b0;
        wait_neg(2);
        rst_btn = 1'b1;
        model_reset();
        wait_neg(2);
    endtask

    task automatic check_cfg(string tag);
        chk({tag, "_displayOn"}, int'(displayOn), m_on);
        chk({tag, "_contrast"}, int'(contrast), m_contrast);
        chk({tag, "_inverted"}, int'(inverted), m_inv);
        chk({tag, "_entireOn"}, int'(entireOn), m_ent);
        chk({tag, "_chargePump"}, int'(chargePump), m_cp);
        chk({tag, "_startLine"}, int'(startLine), m_start);
        chk({tag, "_segRemap"}, int'(segRemap), m_seg);
        chk({tag, "_comScanDec"}, int'(comScanDec), m_com);
        chk({tag, "_muxRatio"}, int'(muxRatio), m_mux);
        chk({tag, "_displayOffset"}, int'(displayOffset), m_off);
        chk({tag, "_addrMode"}, int'(addrMode), m_mode);
    endtask

    int win_exp[5] = '{272, 273, 400, 401, 272};
    int ops[25] = '{'hAE, 'hAF, 'hA6, 'hA7, 'hA4, 'hA5, 'h40, 'hA0, 'hA1,
                    'hC0, 'hC8, 'hB0, 'h00, 'h10, 'h81, 'h20, 'hA8, 'hD3,
                    'h8D, 'hD5, 'hD9, 'hDB, 'h21, 'h22, 'hE3};

    initial begin
        int b0;
        int op;
        int na;
        int hp;
        ioCs = 1'b1; ioSclk = 1'b0; ioSdin = 1'b0; ioDc = 1'b0;
        ioReset = 1'b1;
        rst_btn = 1'b0;
        model_reset();
        wait_neg(2);
        rst_btn = 1'b1;

        // Reset values
        chk("rst_fbWe", int'(fbWe), 0);
        chk("rst_fbAddr", int'(fbAddr), 0);
        chk("rst_fbData", int'(fbData), 0);
        chk("rst_byteValid", int'(byteValid), 0);
        chk("rst_byteData", int'(byteData), 0);
        chk("rst_byteIsData", int'(byteIsData), 0);
        check_cfg("rst");
        wait_neg(10);
        chk("rst_no_bytes", bcount, 0);
        chk("rst_no_writes", wlog.size(), 0);

        // Command plus argument
        send_byte(8'h81, 1'b0, 2);
        send_byte(8'h3C, 1'b0, 2);
        drain();
        chk("cmd_contrast", int'(contrast), 'h3C);
        chk("cmd_byte_count", bcount, 2);
        chk("cmd_no_writes", wlog.size(), 0);
        check_cfg("cmd");

        // Full horizontal sweep with 1-cycle half-period
        do_reset();
        send_byte(8'h20, 1'b0, 1);
        send_byte(8'h00, 1'b0, 1);
        wlog.delete();
        for (int n = 0; n < 1025; n++) send_byte(8'(n), 1'b1, 1);
        drain();
        chk("sweep_count", wlog.size(), 1025);
        if (wlog.size() == 1025) begin
            chk("sweep_300", wlog[300], 300);
            chk("sweep_1023", wlog[1023], 1023);
            chk("sweep_wrap", wlog[1024], 0);
        end

        // Window addressing
        do_reset();
        send_byte(8'h20, 1'b0, 2); send_byte(8'h00, 1'b0, 2);
        send_byte(8'h21, 1'b0, 2); send_byte(8'h10, 1'b0, 2);
        send_byte(8'h11, 1'b0, 2);
        send_byte(8'h22, 1'b0, 2); send_byte(8'h02, 1'b0, 2);
        send_byte(8'h03, 1'b0, 2);
        wlog.delete();
        for (int n = 0; n < 5; n++) send_byte(8'($urandom), 1'b1, 2);
        drain();
        chk("win_count", wlog.size(), 5);
        if (wlog.size() == 5)
            for (int n = 0; n < 5; n++) chk("win_addr", wlog[n], win_exp[n]);

        // Abort by data, partial byte, CS rise on last bit
        do_reset();
        wlog.delete();
        send_byte(8'h81, 1'b0, 2);
        send_byte(8'hAA, 1'b1, 2);
        drain();
        chk("abort_contrast", int'(contrast), 'h7F);
        chk("abort_write_count", wlog.size(), 1);
        if (wlog.size() == 1) chk("abort_write_addr", wlog[0], 0);
        b0 = bcount;
        send_bits(8'h5A, 5, 2);
        cs_high();
        send_byte(8'hAF, 1'b0, 2);
        drain();
        chk("partial_byte_count", bcount - b0, 1);
        chk("partial_displayOn", int'(displayOn), 1);
        send_byte(8'hA7, 1'b0, 2, 1);
        drain();
        chk("cs_last_inverted", int'(inverted), 1);

        // ioReset mid-stream
        do_reset();
        send_byte(8'h81, 1'b0, 2);
        send_byte(8'h10, 1'b0, 2);
        drain();
        chk("midrst_pre_contrast", int'(contrast), 'h10);
        send_bits(8'hFF, 3, 1);
        ioReset = 1'b0;
        wait_neg(1);
        ioReset = 1'b1;
        model_reset();
        wait_neg(4);
        chk("midrst_contrast", int'(contrast), 'h7F);
        send_byte(8'hAF, 1'b0, 2);
        drain();
        chk("midrst_displayOn", int'(displayOn), 1);
        check_cfg("midrst");

        // Randomised traffic
        do_reset();
        for (int it = 0; it < 200; it++) begin
            hp = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 0) begin
                send_byte(8'($urandom), 1'b1, hp);
            end else begin
                op = ops[$urandom_range(0, 24)];
                if (op == 'h40) op = op + $urandom_range(0, 63);
                else if (op == 'hB0) op = op + $urandom_range(0, 7);
                else if (op == 'h00 || op == 'h10) op = op + $urandom_range(0, 15);
                send_byte(8'(op), 1'b0, hp);
                na = nargs(op);
                if (na > 0 && $urandom_range(0, 9) == 0) na = na - 1;
                for (int a = 0; a < na; a++) send_byte(8'($urandom), 1'b0, hp);
            end
            if (it % 50 == 49) begin
                drain();
                check_cfg("rand");
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
